// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: FSM states, ALU operations,
// instruction opcode/command fields and the cmd -> ALU translation.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // MOV runs through the adder; the mov_selec output makes the ALU pass SrcB.
    function automatic logic [3:0] alu_sel(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

    function automatic logic cmd_known(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
               (cmd == CMD_ORR) || (cmd == CMD_CMP) || (cmd == CMD_MOV);
    endfunction

    function automatic logic cmd_arith(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation: cond field against the stored NZCV flags.
module cond_check (
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            4'b0000: cond_ex_o = z;
            4'b0001: cond_ex_o = ~z;
            4'b0010: cond_ex_o = c;
            4'b0011: cond_ex_o = ~c;
            4'b0100: cond_ex_o = n;
            4'b0101: cond_ex_o = ~n;
            4'b0110: cond_ex_o = v;
            4'b0111: cond_ex_o = ~v;
            4'b1000: cond_ex_o = c & ~z;
            4'b1001: cond_ex_o = ~c | z;
            4'b1010: cond_ex_o = (n == v);
            4'b1011: cond_ex_o = (n != v);
            4'b1100: cond_ex_o = ~z & (n == v);
            4'b1101: cond_ex_o = z | (n != v);
            4'b1110: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset sequencer: one FSM steps each instruction through
// fetch/decode/execute/writeback and owns the NZCV flags register.
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic        mov_selec,
    output state_t      dbg_state_o,
    output logic [3:0]  dbg_flags_o
);

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex;

    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic       bit_i, bit_s, rd_is_pc;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign bit_i     = Instr[13];
    assign cmd       = Instr[12:9];
    assign bit_s     = Instr[8];
    assign rd        = Instr[3:0];
    assign rd_is_pc  = (rd == 4'hF);
    assign unused_rn = ^Instr[7:4];

    cond_check u_cond_check (
        .cond_i    (cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        case (state_q)
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_ex || op == 2'b11) state_d = S_FETCH;
                else if (op == OP_DP)        state_d = bit_i ? S_EXECI : S_EXECR;
                else if (op == OP_MEM)       state_d = S_MEMADR;
                else if (op == OP_BR)        state_d = S_BRANCH;
                else                         state_d = S_FETCH;
            end
            S_MEMADR: state_d = bit_s ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (MemReady) state_d = S_FETCH;
            S_EXECR, S_EXECI: begin
                // Unrecognised commands execute as ADD but must not disturb the flags.
                if (bit_s && cmd_known(cmd)) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (cmd_arith(cmd)) flags_d[1:0] = ALUFlags[1:0];
                end
                state_d = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
            end
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= FLAGS_RESET;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegSrc     = {op == OP_MEM, 1'b0};
        ImmSrc     = op;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ResultSrc  = 2'b00;
        mov_selec  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                PCWrite   = rd_is_pc;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_sel(cmd);
                mov_selec  = (cmd == CMD_MOV);
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                PCWrite  = rd_is_pc;
            end
            S_BRANCH: begin
                RegSrc[0] = 1'b1;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
        // FETCH enables follow MemReady, so reset must mask them explicitly.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_flags_o = flags_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected control
// vectors are queued with the stimulus and compared as the FSM steps.
module tb_multicycle_controller;
    import cpu_ctrl_pkg::*;

    localparam int W = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, mov_selec;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0]  ALUControl;
    state_t      dbg_state;
    logic [3:0]  dbg_flags;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [5:0]   stim_q[$];
    logic [1:0]   cur_op;
    logic [3:0]   cur_rd;
    logic [W-1:0] obs;
    logic [W-1:0] e;

    always #5 clk = ~clk;

    multicycle_controller #(.FLAGS_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .mov_selec(mov_selec), .dbg_state_o(dbg_state), .dbg_flags_o(dbg_flags)
    );

    assign obs = {dbg_state, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, RegSrc, ImmSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ResultSrc, mov_selec};

    function automatic logic [W-1:0] pk(state_t s, logic pcw, logic irw, logic adr, logic mw,
                                        logic rw, logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                        logic [3:0] alu, logic [1:0] res, logic mov);
        return {s, pcw, irw, adr, mw, rw, rs, cur_op, sa, sb, alu, res, mov};
    endfunction

    function automatic logic m1();
        return (cur_op == 2'b01);
    endfunction

    function automatic logic [W-1:0] e_fetch(logic mr);
        return pk(S_FETCH, mr, mr, 1'b0, 1'b0, 1'b0, {m1(), 1'b0}, 2'b01, 2'b10, ALU_ADD, 2'b10, 1'b0);
    endfunction
    function automatic logic [W-1:0] e_decode();
        return pk(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {m1(), 1'b0}, 2'b01, 2'b10, ALU_ADD, 2'b10, 1'b0);
    endfunction
    function automatic logic [W-1:0] e_memadr();
        return pk(S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {m1(), 1'b0}, 2'b00, 2'b01, ALU_ADD, 2'b00, 1'b0);
    endfunction
    function automatic logic [W-1:0] e_memrd();
        return pk(S_MEMRD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {m1(), 1'b0}, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b0);
    endfunction
    function automatic logic [W-1:0] e_memwb();
        return pk(S_MEMWB, cur_rd == 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, {m1(), 1'b0}, 2'b00, 2'b00, ALU_ADD, 2'b01, 1'b0);
    endfunction
    function automatic logic [W-1:0] e_memwr();
        return pk(S_MEMWR, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, {m1(), 1'b0}, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b0);
    endfunction
    function automatic logic [W-1:0] e_exec(logic imm, logic [3:0] alu, logic mov);
        return pk(imm ? S_EXECI : S_EXECR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {m1(), 1'b0}, 2'b00,
                  imm ? 2'b01 : 2'b00, alu, 2'b00, mov);
    endfunction
    function automatic logic [W-1:0] e_aluwb();
        return pk(S_ALUWB, cur_rd == 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, {m1(), 1'b0}, 2'b00, 2'b00, ALU_ADD, 2'b00, 1'b0);
    endfunction
    function automatic logic [W-1:0] e_branch();
        return pk(S_BRANCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {m1(), 1'b1}, 2'b00, 2'b01, ALU_ADD, 2'b10, 1'b0);
    endfunction

    task automatic set_instr(input logic [19:0] v);
        Instr  = v;
        cur_op = v[15:14];
        cur_rd = v[3:0];
    endtask

    // mr drives MemReady; fx=1 pins ALUFlags to af, otherwise ALUFlags is random.
    task automatic push(input logic mr, input logic fx, input logic [3:0] af, input logic [W-1:0] ev);
        stim_q.push_back({mr, fx, af});
        exp_q.push_back(ev);
    endtask

    task automatic push_dc(input logic [W-1:0] ev);
        push(1'($urandom_range(0, 1)), 1'b0, 4'h0, ev);
    endtask

    task automatic drive_next();
        logic [5:0] s;
        s = stim_q.pop_front();
        MemReady = s[5];
        ALUFlags = s[4] ? s[3:0] : 4'($urandom_range(0, 15));
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_instr(20'h00000);
        reset = 1'b1; MemReady = 1'b1; ALUFlags = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (obs !== e_fetch(1'b0)) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, e_fetch(1'b0));
        end
        n_tests++;
        if (dbg_flags !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", dbg_flags);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_add();
        set_instr(20'hE0821);
        push(1'b0, 1'b0, 4'h0, e_fetch(1'b0));
        push(1'b1, 1'b0, 4'h0, e_fetch(1'b1));
        push_dc(e_decode());
        push_dc(e_exec(1'b0, ALU_ADD, 1'b0));
        push_dc(e_aluwb());
        push(1'b0, 1'b0, 4'h0, e_fetch(1'b0));
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL add_seq: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
        n_tests++;
        if (dbg_flags !== 4'b0000) begin
            n_fail++; $display("FAIL add_flags: got %b expected 0000", dbg_flags);
        end
    endtask

    task automatic test_subs_beq();
        set_instr(20'hE0500);
        push(1'b1, 1'b0, 4'h0, e_fetch(1'b1));
        push_dc(e_decode());
        push(1'b0, 1'b1, 4'b0100, e_exec(1'b0, ALU_SUB, 1'b0));
        push_dc(e_aluwb());
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL subs_seq: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
        n_tests++;
        if (dbg_flags !== 4'b0100) begin
            n_fail++; $display("FAIL subs_flags: got %b expected 0100", dbg_flags);
        end
        set_instr(20'h0A000);
        push(1'b1, 1'b0, 4'h0, e_fetch(1'b1));
        push_dc(e_decode());
        push_dc(e_branch());
        push(1'b0, 1'b0, 4'h0, e_fetch(1'b0));
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL beq_seq: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bne();
        set_instr(20'h1A000);
        push(1'b1, 1'b0, 4'h0, e_fetch(1'b1));
        push_dc(e_decode());
        push(1'b0, 1'b0, 4'h0, e_fetch(1'b0));
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL bne_seq: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
        n_tests++;
        if (dbg_flags !== 4'b0100) begin
            n_fail++; $display("FAIL bne_flags: got %b expected 0100", dbg_flags);
        end
    endtask

    task automatic test_reset_mid_mem();
        set_instr(20'hE5910);
        push(1'b1, 1'b0, 4'h0, e_fetch(1'b1));
        push_dc(e_decode());
        push_dc(e_memadr());
        push(1'b0, 1'b0, 4'h0, e_memrd());
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL rstmid_seq: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
        MemReady = 1'b1;
        reset = 1'b1;
        #1;
        n_tests++;
        if (obs !== e_fetch(1'b0)) begin
            n_fail++; $display("FAIL rstmid_async: got %h expected %h", obs, e_fetch(1'b0));
        end
        n_tests++;
        if (dbg_flags !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_flags: got %b expected 0000", dbg_flags);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        push(1'b0, 1'b0, 4'h0, e_fetch(1'b0));
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL rstmid_after: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ldr();
        set_instr(20'hE5910);
        push(1'b1, 1'b0, 4'h0, e_fetch(1'b1));
        push_dc(e_decode());
        push_dc(e_memadr());
        repeat (3) push(1'b0, 1'b0, 4'h0, e_memrd());
        push(1'b1, 1'b0, 4'h0, e_memrd());
        push_dc(e_memwb());
        push(1'b0, 1'b0, 4'h0, e_fetch(1'b0));
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL ldr_seq: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cmp();
        set_instr(20'hE1510);
        push(1'b1, 1'b0, 4'h0, e_fetch(1'b1));
        push_dc(e_decode());
        push(1'b0, 1'b1, 4'b0110, e_exec(1'b0, ALU_SUB, 1'b0));
        push(1'b0, 1'b0, 4'h0, e_fetch(1'b0));
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL cmp_seq: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
        n_tests++;
        if (dbg_flags !== 4'b0110) begin
            n_fail++; $display("FAIL cmp_flags: got %b expected 0110", dbg_flags);
        end
    endtask

    task automatic test_op11();
        set_instr(20'hEC000);
        push(1'b1, 1'b0, 4'h0, e_fetch(1'b1));
        push_dc(e_decode());
        push(1'b0, 1'b0, 4'h0, e_fetch(1'b0));
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL op11_seq: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_str();
        set_instr(20'hE5810);
        push(1'b1, 1'b0, 4'h0, e_fetch(1'b1));
        push_dc(e_decode());
        push_dc(e_memadr());
        repeat (2) push(1'b0, 1'b0, 4'h0, e_memwr());
        push(1'b1, 1'b0, 4'h0, e_memwr());
        push(1'b0, 1'b0, 4'h0, e_fetch(1'b0));
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL str_seq: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] model_flags = 4'b0110;
        for (int k = 0; k < 12; k++) begin
            int         sel  = $urandom_range(0, 4);
            int         wait_n = $urandom_range(0, 2);
            logic [3:0] r    = 4'($urandom_range(0, 15));
            logic [19:0] ins;
            logic        imm, mov;
            logic [3:0]  alu;
            case (sel)
                0:       begin ins = 20'hE0821; imm = 1'b0; alu = ALU_ADD; mov = 1'b0; end
                1:       begin ins = 20'hE3811; imm = 1'b1; alu = ALU_ORR; mov = 1'b0; end
                2:       begin ins = 20'hE1A02; imm = 1'b0; alu = ALU_ADD; mov = 1'b1; end
                3:       begin ins = 20'hE0112; imm = 1'b0; alu = ALU_AND; mov = 1'b0; end
                default: begin ins = 20'hE082F; imm = 1'b0; alu = ALU_ADD; mov = 1'b0; end
            endcase
            if (sel == 3) model_flags[3:2] = r[3:2];
            set_instr(ins);
            for (int j = 0; j < wait_n; j++) push(1'b0, 1'b0, 4'h0, e_fetch(1'b0));
            push(1'b1, 1'b0, 4'h0, e_fetch(1'b1));
            push_dc(e_decode());
            push(1'($urandom_range(0, 1)), 1'b1, r, e_exec(imm, alu, mov));
            push_dc(e_aluwb());
            while (exp_q.size() != 0) begin
                drive_next();
                e = exp_q.pop_front();
                n_tests++;
                if (obs !== e) begin
                    n_fail++; $display("FAIL b2b_seq instr=%h: got %h expected %h", ins, obs, e);
                end
                @(posedge clk); #1;
            end
            n_tests++;
            if (dbg_flags !== model_flags) begin
                n_fail++; $display("FAIL b2b_flags instr=%h: got %b expected %b", ins, dbg_flags, model_flags);
            end
        end
    endtask

    initial begin
        reset = 1'b1; Instr = 20'h0; ALUFlags = 4'h0; MemReady = 1'b0;
        cur_op = 2'b00; cur_rd = 4'h0;
        test_reset();
        test_add();
        test_subs_beq();
        test_bne();
        test_reset_mid_mem();
        test_ldr();
        test_cmp();
        test_op11();
        test_str();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
